// File: rtl/booth_pkg.sv
// booth_pkg -- shared types for the sequential radix-4 Booth multiplier.
//   booth_state_e : controller states (IDLE, RUN, DONE)
//   booth_op_e    : partial-product selection produced by the Booth recoder
//   booth_decode  : maps a multiplier bit triplet to its partial-product selection
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} booth_state_e;

  typedef enum {B_ZERO, B_P1, B_P2, B_M1, B_M2} booth_op_e;

  function automatic booth_op_e booth_decode(input logic [2:0] trip);
    booth_op_e op;
    case (trip)
      3'b001, 3'b010: op = B_P1;
      3'b011:         op = B_P2;
      3'b100:         op = B_M2;
      3'b101, 3'b110: op = B_M1;
      default:        op = B_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if -- start/busy/done handshake bundle of the Booth multiplier.
//   start, is_signed, multiplier, multiplicand : request side (driven by master)
//   product, busy, done                        : result side (driven by slave)
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, is_signed, multiplier, multiplicand,
    input  product, busy, done
  );

  modport slave (
    input  start, is_signed, multiplier, multiplicand,
    output product, busy, done
  );
endinterface

// File: rtl/booth_pp_gen.sv
// booth_pp_gen -- combinational radix-4 Booth partial-product generator.
//   trip  : multiplier triplet {b[i+1], b[i], b[i-1]}
//   mcand : extended multiplicand (EXT bits, signed)
//   pp    : selected partial product 0, +-M or +-2M (EXT+1 bits, signed)
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int EXT = 10
) (
  input  logic [2:0]            trip,
  input  logic signed [EXT-1:0] mcand,
  output logic signed [EXT:0]   pp
);

  booth_op_e            op;
  logic signed [EXT:0]  m1;

  always_comb begin
    op = booth_decode(trip);
    m1 = {mcand[EXT-1], mcand};
    // 2M cannot overflow: the extended multiplicand carries two sign/zero bits.
    case (op)
      B_P1:    pp = m1;
      B_P2:    pp = m1 <<< 1;
      B_M1:    pp = -m1;
      B_M2:    pp = -(m1 <<< 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq -- sequential radix-4 Booth multiplier, 2 multiplier bits per clock.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : booth_mult_seq_if slave (start/is_signed/operands in, product/busy/done out)
// Operands are latched on an accepted start (IDLE or DONE) and sign- or zero-extended
// to WIDTH+2 bits, so signed and unsigned products share one datapath. The result is
// registered on the edge leaving DONE, giving done one clock after the DONE state.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  booth_mult_seq_if.slave bus
);

  localparam int EXT = WIDTH + 2;
  localparam int NIT = WIDTH / 2 + 1;
  localparam int CW  = $clog2(NIT + 1);
  localparam int AW  = 2 * EXT + 1;

  if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_width_check
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end

  function automatic logic [EXT-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {{2{sgn & v[WIDTH-1]}}, v};
  endfunction

  booth_state_e          state_q, state_nxt;
  logic                  accept;
  logic signed [EXT-1:0] mcand_q;
  logic [AW-1:0]         acc_q;
  logic [CW-1:0]         cnt_q;
  logic [2*WIDTH-1:0]    product_q;
  logic                  done_q;

  logic [EXT-1:0]        upper;
  logic signed [EXT:0]   pp;
  logic signed [EXT:0]   sum;
  logic [AW-1:0]         acc_nxt;

  booth_pp_gen #(.EXT(EXT)) u_pp_gen (
    .trip  (acc_q[2:0]),
    .mcand (mcand_q),
    .pp    (pp)
  );

  // Step: add the partial product into the upper field (one extra bit of headroom),
  // then arithmetic shift the whole accumulator right by two.
  always_comb begin
    upper   = acc_q[AW-1:EXT+1];
    sum     = $signed({upper[EXT-1], upper}) + pp;
    acc_nxt = {sum[EXT], sum, acc_q[EXT:2]};
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(NIT - 1)) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      done_q  <= (state_q == DONE);
      // The finished product sits in acc bits [2*WIDTH:1]; bit 0 is the Booth seed.
      if (state_q == DONE) product_q <= acc_q[2*WIDTH:1];
      if (accept) begin
        mcand_q <= extend(bus.multiplicand, bus.is_signed);
        acc_q   <= {{EXT{1'b0}}, extend(bus.multiplier, bus.is_signed), 1'b0};
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;

endmodule
